alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//   Upstream driver for the 16-bit ALU. Accepts an operation request over valid/ready,
//   drives the ALU operand, select, carry and enable pins, and captures data, carry and zero.
//   Returns the captured result over valid/ready.
//   Chains two ALU passes, low word then high word, for 32-bit ADD/SUB.
// PARAMETERS
//   WIDTH   16  ALU word width; request/response operands are 2*WIDTH
//   SEL_W   3   ALU select width
//   SETTLE  1   cycles alu_enable is held per pass before capture (>=1)
// PORTS
//   clk            in   1         single clock, rising edge
//   rst_n          in   1         asynchronous, active-low reset
//   req_valid      in   1         request present
//   req_ready      out  1         sequencer idle, request accepted when valid&&ready
//   req_op         in   SEL_W     ALU select code for this request
//   req_wide       in   1         1 = two-pass 2*WIDTH operation
//   req_a          in   2*WIDTH   operand A (narrow: low WIDTH bits used)
//   req_b          in   2*WIDTH   operand B (narrow: low WIDTH bits used)
//   req_carry      in   1         carry into the low-word pass
//   alu_in_1       out  WIDTH     ALU operand 1
//   alu_in_2       out  WIDTH     ALU operand 2
//   alu_carry_in   out  1         ALU carry in
//   alu_enable     out  1         ALU output enable (ALU tri-states its outputs when 0)
//   alu_select     out  SEL_W     ALU operation select
//   alu_data       in   WIDTH     ALU result bus
//   alu_carry_out  in   1         ALU carry out
//   alu_zero_flag  in   1         ALU zero flag
//   rsp_valid      out  1         result available
//   rsp_ready      in   1         consumer accepts result
//   rsp_result     out  2*WIDTH   result (narrow: upper WIDTH bits = 0)
//   rsp_carry      out  1         carry_out of the final pass
//   rsp_zero       out  1         1 when the whole rsp_result is zero
// BEHAVIOUR
//   - Reset: state IDLE; req_ready=1; alu_enable=0; alu_in_1/2, alu_select, alu_carry_in=0.
//     rsp_valid=0; rsp_result, rsp_carry, rsp_zero=0.
//     Assertion mid-operation aborts immediately and drops alu_enable asynchronously.
//     The in-flight result is discarded.
//   - All ALU-side outputs are registered.
//   - alu_data/carry/zero are sampled only on the last cycle of an EXEC state.
//     Z/X on these inputs is ignored while alu_enable=0.
//   - FSM: IDLE -> EXEC_LO on accept. req_ready=1 only in IDLE. A/B/op/wide/carry are latched.
//     EXEC_LO: alu_enable=1; drive low words, req_op and req_carry for SETTLE cycles.
//       Capture data->result[WIDTH-1:0], carry_lo, zero_lo.
//       Next state is GAP if wide, else RESP.
//     GAP: alu_enable=0 for exactly 1 cycle (bus turnaround); next EXEC_HI.
//     EXEC_HI: drive the high words for SETTLE cycles.
//       alu_carry_in = carry_lo for op ADD/SUB, else 0.
//       Capture the upper result word, carry_hi and zero_hi; next RESP.
//     RESP: rsp_valid=1; outputs stable until rsp_ready. Handshake -> IDLE.
//   - rsp_carry = carry of the last pass.
//     rsp_zero = zero_lo (narrow) or zero_lo & zero_hi (wide).
//   - Latency, accept edge to rsp_valid: narrow SETTLE+1 cycles; wide 2*SETTLE+2 cycles.
//   - No overlap: the next request is accepted no earlier than the cycle after the rsp handshake.
//   - rsp_ready held high: RESP lasts 1 cycle.
//   - req_valid dropping while busy has no effect.
//   - Unknown op codes pass through to alu_select unchanged; the carry is not chained (carry_in=0).
// STRUCTURE
//   - Shared package alu_pkg holds:
//     - ALU_ADD=3'd0, ALU_SUB=3'd1, ALU_NOT=3'd5;
//     - sequencer state encoding (IDLE, EXEC_LO, GAP, EXEC_HI, RESP);
//     - WIDTH default.
//   - No sub-module. The SETTLE counter and the FSM are inline.
// TESTING (bench pairs this block with the ALU; SETTLE=1)
//   1. Reset mid EXEC_LO -> alu_enable=0 at once; rsp_valid=0; req_ready=1 after release.
//   2. Narrow ADD 5+3, carry 0 -> rsp_result=32'd8, rsp_carry=0, rsp_zero=0.
//      rsp_valid 2 cycles after accept.
//   3. Narrow NOT, a=16'hFFFF -> rsp_result=0, rsp_zero=1, rsp_carry=1.
//   4. Wide ADD 32'h0000_FFFF+32'h0000_0001 -> 32'h0001_0000, carry 0, zero 0.
//      One GAP cycle with alu_enable=0 is visible.
//   5. Wide ADD 32'hFFFF_FFFF+1 -> result 0, rsp_carry=1, rsp_zero=1.
//      rsp_valid 4 cycles after accept.
//   6. rsp_ready held 0 for 5 cycles with a new req_valid asserted -> result stable, req_ready=0.
//      Accept occurs the cycle after the rsp handshake.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, sequencer state encoding, default word width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  localparam int ALU_WIDTH = 16;
  localparam int ALU_SEL_W = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_NOT = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC_LO = 3'd1,
    GAP     = 3'd2,
    EXEC_HI = 3'd3,
    RESP    = 3'd4
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Drives a 16-bit ALU for one request, chaining low/high passes for 32-bit ops.
// Latency: accept edge to rsp_valid is SETTLE+1 (narrow) or 2*SETTLE+2 (wide) cycles.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SEL_W-1:0]     req_op,
  input  logic                 req_wide,
  input  logic [2*WIDTH-1:0]   req_a,
  input  logic [2*WIDTH-1:0]   req_b,
  input  logic                 req_carry,
  output logic [WIDTH-1:0]     alu_in_1,
  output logic [WIDTH-1:0]     alu_in_2,
  output logic                 alu_carry_in,
  output logic                 alu_enable,
  output logic [SEL_W-1:0]     alu_select,
  input  logic [WIDTH-1:0]     alu_data,
  input  logic                 alu_carry_out,
  input  logic                 alu_zero_flag,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*WIDTH-1:0]   rsp_result,
  output logic                 rsp_carry,
  output logic                 rsp_zero
);

  // Counter spans 0..SETTLE. The ALU pins are registered one cycle behind the
  // FSM, so the first EXEC_LO cycle launches the operands and the following
  // SETTLE cycles are the enabled settle window; GAP launches the high operands.
  localparam int              CNT_W    = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  seq_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   req_ready_q, req_ready_d;
  logic [2*WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]     b_q, b_d;
  logic [SEL_W-1:0]       op_q, op_d;
  logic                   wide_q, wide_d;
  logic                   carry_q, carry_d;
  logic [WIDTH-1:0]       alu_in_1_q, alu_in_1_d;
  logic [WIDTH-1:0]       alu_in_2_q, alu_in_2_d;
  logic                   alu_carry_in_q, alu_carry_in_d;
  logic                   alu_enable_q, alu_enable_d;
  logic [SEL_W-1:0]       alu_select_q, alu_select_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]     rsp_result_q, rsp_result_d;
  logic                   rsp_carry_q, rsp_carry_d;
  logic                   rsp_zero_q, rsp_zero_d;
  logic                   zero_lo_q, zero_lo_d;
  logic                   chains_carry;

  // Only ADD/SUB propagate the low-pass carry into the high pass.
  assign chains_carry = (op_q == SEL_W'(ALU_ADD)) || (op_q == SEL_W'(ALU_SUB));

  // Next-state, ALU pin and result capture logic.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_ready_d    = req_ready_q;
    a_d            = a_q;
    b_d            = b_q;
    op_d           = op_q;
    wide_d         = wide_q;
    carry_d        = carry_q;
    alu_in_1_d     = alu_in_1_q;
    alu_in_2_d     = alu_in_2_q;
    alu_carry_in_d = alu_carry_in_q;
    alu_enable_d   = alu_enable_q;
    alu_select_d   = alu_select_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_result_d   = rsp_result_q;
    rsp_carry_d    = rsp_carry_q;
    rsp_zero_d     = rsp_zero_q;
    zero_lo_d      = zero_lo_q;

    case (state_q)
      IDLE: begin
        alu_enable_d = 1'b0;
        req_ready_d  = 1'b1;
        if (req_valid && req_ready_q) begin
          a_d          = req_a;
          b_d          = req_b;
          op_d         = req_op;
          wide_d       = req_wide;
          carry_d      = req_carry;
          rsp_result_d = '0;
          cnt_d        = '0;
          req_ready_d  = 1'b0;
          state_d      = EXEC_LO;
        end
      end

      EXEC_LO: begin
        alu_in_1_d     = a_q[WIDTH-1:0];
        alu_in_2_d     = b_q[WIDTH-1:0];
        alu_select_d   = op_q;
        alu_carry_in_d = carry_q;
        if (cnt_q == CNT_LAST) begin
          alu_enable_d              = 1'b0;
          rsp_result_d[WIDTH-1:0]   = alu_data;
          rsp_carry_d               = alu_carry_out;
          rsp_zero_d                = alu_zero_flag;
          zero_lo_d                 = alu_zero_flag;
          cnt_d                     = '0;
          if (wide_q) begin
            state_d = GAP;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end else begin
          alu_enable_d = 1'b1;
          cnt_d        = cnt_q + CNT_ONE;
        end
      end

      GAP: begin
        // Bus turnaround: pins show enable=0 this cycle while the high words load.
        alu_enable_d   = 1'b1;
        alu_in_1_d     = a_q[2*WIDTH-1:WIDTH];
        alu_in_2_d     = b_q[2*WIDTH-1:WIDTH];
        alu_carry_in_d = chains_carry ? rsp_carry_q : 1'b0;
        cnt_d          = CNT_ONE;
        state_d        = EXEC_HI;
      end

      EXEC_HI: begin
        if (cnt_q == CNT_LAST) begin
          alu_enable_d                    = 1'b0;
          rsp_result_d[2*WIDTH-1:WIDTH]   = alu_data;
          rsp_carry_d                     = alu_carry_out;
          rsp_zero_d                      = zero_lo_q & alu_zero_flag;
          rsp_valid_d                     = 1'b1;
          cnt_d                           = '0;
          state_d                         = RESP;
        end else begin
          alu_enable_d = 1'b1;
          cnt_d        = cnt_q + CNT_ONE;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        alu_enable_d = 1'b0;
        rsp_valid_d  = 1'b0;
        req_ready_d  = 1'b1;
        state_d      = IDLE;
      end
    endcase
  end

  // FSM and all registered outputs; reset aborts any pass and drops alu_enable at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      req_ready_q    <= 1'b1;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      wide_q         <= 1'b0;
      carry_q        <= 1'b0;
      alu_in_1_q     <= '0;
      alu_in_2_q     <= '0;
      alu_carry_in_q <= 1'b0;
      alu_enable_q   <= 1'b0;
      alu_select_q   <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_result_q   <= '0;
      rsp_carry_q    <= 1'b0;
      rsp_zero_q     <= 1'b0;
      zero_lo_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_ready_q    <= req_ready_d;
      a_q            <= a_d;
      b_q            <= b_d;
      op_q           <= op_d;
      wide_q         <= wide_d;
      carry_q        <= carry_d;
      alu_in_1_q     <= alu_in_1_d;
      alu_in_2_q     <= alu_in_2_d;
      alu_carry_in_q <= alu_carry_in_d;
      alu_enable_q   <= alu_enable_d;
      alu_select_q   <= alu_select_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_result_q   <= rsp_result_d;
      rsp_carry_q    <= rsp_carry_d;
      rsp_zero_q     <= rsp_zero_d;
      zero_lo_q      <= zero_lo_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign alu_in_1     = alu_in_1_q;
  assign alu_in_2     = alu_in_2_q;
  assign alu_carry_in = alu_carry_in_q;
  assign alu_enable   = alu_enable_q;
  assign alu_select   = alu_select_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_zero     = rsp_zero_q;

endmodule
